// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with valid/ready handshake and mult/div issue sequencer.
// Define ALU_CTRL_MD_EN to build in the mult/div decode, occupancy counter and MD_BUSY state.
module alu_ctrl_seq #(
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [1:0]        i_alu_op,
  input  logic [5:0]        i_funct,
  input  logic              i_flush,
  output logic              o_out_valid,
  output logic [CTRL_W-1:0] o_out_ctrl,
  output logic              o_illegal,
  output logic              o_md_start,
  output logic              o_md_busy,
  output logic              o_md_done
);

  logic [3:0] w_code;
  logic       w_illegal;
  logic       w_is_md;
  logic       w_accept;

  always_comb begin
    w_code    = 4'b0000;
    w_illegal = 1'b0;
    w_is_md   = 1'b0;
    unique case (i_alu_op)
      2'b00: w_code = 4'b0010;
      2'b01: w_code = 4'b0110;
      2'b11: w_code = 4'b0111;
      default: begin
        case (i_funct)
          6'b100000: w_code = 4'b0010;
          6'b100010: w_code = 4'b0110;
          6'b100100: w_code = 4'b0000;
          6'b100101: w_code = 4'b0001;
          6'b100111: w_code = 4'b1100;
          6'b101010: w_code = 4'b0111;
`ifdef ALU_CTRL_MD_EN
          6'b011000: begin
            w_code  = 4'b1000;
            w_is_md = 1'b1;
          end
          6'b011010: begin
            w_code  = 4'b1001;
            w_is_md = 1'b1;
          end
`endif
          default: begin
            w_code    = 4'b0000;
            w_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  assign w_accept = i_in_valid & o_in_ready & ~i_flush;

  // Decode outputs: flush blocks the accept, so it also clears the pulses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_out_valid <= 1'b0;
      o_out_ctrl  <= '0;
      o_illegal   <= 1'b0;
    end else begin
      o_out_valid <= w_accept;
      o_illegal   <= w_accept & w_illegal;
      if (w_accept)
        o_out_ctrl <= CTRL_W'(w_code);
    end
  end

`ifdef ALU_CTRL_MD_EN
  localparam int CNT_W = $clog2(MD_CYCLES);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MD_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;

  assign o_in_ready = ~o_md_busy;

  // md_done is registered one edge early so it lines up with the count-0 cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      o_md_start <= 1'b0;
      o_md_busy  <= 1'b0;
      o_md_done  <= 1'b0;
    end else begin
      o_md_start <= 1'b0;
      o_md_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_md) begin
            r_state    <= S_MD_BUSY;
            r_cnt      <= CNT_W'(MD_CYCLES - 1);
            o_md_start <= 1'b1;
            o_md_busy  <= 1'b1;
          end
        end
        S_MD_BUSY: begin
          if (i_flush) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            o_md_busy <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state   <= S_IDLE;
            o_md_busy <= 1'b0;
          end else begin
            r_cnt     <= r_cnt - 1'b1;
            o_md_done <= (r_cnt == CNT_W'(1));
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          o_md_busy <= 1'b0;
        end
      endcase
    end
  end
`else
  assign o_in_ready = 1'b1;
  assign o_md_start = 1'b0;
  assign o_md_busy  = 1'b0;
  assign o_md_done  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed self-checking bench for alu_ctrl_seq (CTRL_W=4, MD_CYCLES=4).
// Expectations follow ALU_CTRL_MD_EN when it is defined for the build.
module tb_alu_ctrl_seq;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic       flush;
  logic       out_valid;
  logic [3:0] out_ctrl;
  logic       illegal;
  logic       md_start;
  logic       md_busy;
  logic       md_done;

  int n_tests = 0;
  int n_fail  = 0;

  alu_ctrl_seq #(.CTRL_W(4), .MD_CYCLES(4)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_alu_op    (alu_op),
    .i_funct     (funct),
    .i_flush     (flush),
    .o_out_valid (out_valid),
    .o_out_ctrl  (out_ctrl),
    .o_illegal   (illegal),
    .o_md_start  (md_start),
    .o_md_busy   (md_busy),
    .o_md_done   (md_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".out_ctrl"},  32'(out_ctrl),  32'd0);
    check({tag, ".illegal"},   32'(illegal),   32'd0);
    check({tag, ".md_start"},  32'(md_start),  32'd0);
    check({tag, ".md_busy"},   32'(md_busy),   32'd0);
    check({tag, ".md_done"},   32'(md_done),   32'd0);
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
  endtask

  logic [5:0] r_functs [6] = '{6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b100000, 6'b100010};
  logic [3:0] r_codes  [6] = '{4'b0000,   4'b0001,   4'b1100,   4'b0111,   4'b0010,   4'b0110};

  initial begin
    reset = 1'b1; in_valid = 1'b0; alu_op = 2'b00; funct = 6'b0; flush = 1'b0;
    tick();
    check_reset_vals("rst");
    reset = 1'b0;

    in_valid = 1'b1; alu_op = 2'b00;
    tick();
    check("lw.valid", 32'(out_valid), 32'd1);
    check("lw.ctrl",  32'(out_ctrl),  32'h2);
    check("lw.ill",   32'(illegal),   32'd0);
    alu_op = 2'b01;
    tick();
    check("beq.valid", 32'(out_valid), 32'd1);
    check("beq.ctrl",  32'(out_ctrl),  32'h6);
    alu_op = 2'b11;
    tick();
    check("slti.ctrl", 32'(out_ctrl), 32'h7);

    alu_op = 2'b10;
    for (int i = 0; i < 6; i++) begin
      funct = r_functs[i];
      tick();
      check($sformatf("r%0d.valid", i), 32'(out_valid), 32'd1);
      check($sformatf("r%0d.ctrl", i),  32'(out_ctrl),  32'(r_codes[i]));
      check($sformatf("r%0d.ill", i),   32'(illegal),   32'd0);
    end
    funct = 6'b111111;
    tick();
    check("bad.valid", 32'(out_valid), 32'd1);
    check("bad.ctrl",  32'(out_ctrl),  32'h0);
    check("bad.ill",   32'(illegal),   32'd1);

    in_valid = 1'b0;
    tick();
    check("idle.valid", 32'(out_valid), 32'd0);
    check("idle.ill",   32'(illegal),   32'd0);

    in_valid = 1'b1; alu_op = 2'b01; flush = 1'b1;
    tick();
    check("flushin.valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();

    // Mult accepted at edge T, a plain request held behind it.
    in_valid = 1'b1; alu_op = 2'b10; funct = 6'b011000;
    tick();
`ifdef ALU_CTRL_MD_EN
    check("mul.valid", 32'(out_valid), 32'd1);
    check("mul.ctrl",  32'(out_ctrl),  32'h8);
    check("mul.start", 32'(md_start),  32'd1);
    check("mul.busy1", 32'(md_busy),   32'd1);
    check("mul.rdy1",  32'(in_ready),  32'd0);
    check("mul.done1", 32'(md_done),   32'd0);
    alu_op = 2'b00;
    tick();
    check("mul.start2", 32'(md_start),  32'd0);
    check("mul.busy2",  32'(md_busy),   32'd1);
    check("mul.valid2", 32'(out_valid), 32'd0);
    tick();
    check("mul.busy3", 32'(md_busy), 32'd1);
    check("mul.done3", 32'(md_done), 32'd0);
    tick();
    check("mul.busy4", 32'(md_busy),   32'd1);
    check("mul.done4", 32'(md_done),   32'd1);
    check("mul.valid4", 32'(out_valid), 32'd0);
    tick();
    check("mul.busy5", 32'(md_busy),   32'd0);
    check("mul.done5", 32'(md_done),   32'd0);
    check("mul.rdy5",  32'(in_ready),  32'd1);
    check("mul.valid5", 32'(out_valid), 32'd0);
    tick();
    check("held.valid", 32'(out_valid), 32'd1);
    check("held.ctrl",  32'(out_ctrl),  32'h2);
`else
    check("mul.valid", 32'(out_valid), 32'd1);
    check("mul.ctrl",  32'(out_ctrl),  32'h0);
    check("mul.ill",   32'(illegal),   32'd1);
    check("mul.start", 32'(md_start),  32'd0);
    alu_op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("mul.busy%0d", i), 32'(md_busy),  32'd0);
      check($sformatf("mul.rdy%0d", i),  32'(in_ready), 32'd1);
      check($sformatf("mul.ov%0d", i),   32'(out_valid), 32'd1);
    end
`endif

    // Div, then flush in busy cycle 2.
    alu_op = 2'b10; funct = 6'b011010;
    tick();
    in_valid = 1'b0;
`ifdef ALU_CTRL_MD_EN
    check("div.ctrl",  32'(out_ctrl), 32'h9);
    check("div.busy1", 32'(md_busy),  32'd1);
`else
    check("div.ill",   32'(illegal),  32'd1);
`endif
    tick();
`ifdef ALU_CTRL_MD_EN
    check("div.busy2", 32'(md_busy), 32'd1);
`endif
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush.busy", 32'(md_busy),  32'd0);
    check("flush.done", 32'(md_done),  32'd0);
    check("flush.rdy",  32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("flush.done%0d", i), 32'(md_done), 32'd0);
    end

    // Reset mid-busy must clear everything without waiting for a clock.
    in_valid = 1'b1; alu_op = 2'b10; funct = 6'b011000;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    tick();
    reset = 1'b0;
    check_reset_vals("midrst2");

    in_valid = 1'b1; alu_op = 2'b10; funct = 6'b100111;
    tick();
    in_valid = 1'b0;
    check("post.valid", 32'(out_valid), 32'd1);
    check("post.ctrl",  32'(out_ctrl),  32'hC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
